// File: rtl/conv1_pkg.sv
`default_nettype none
// ============================================================================
// Package  : conv1_pkg
// Purpose  : Shared widths and types for the conv1 3x3x3 window generator.
// Revision : 1.0 - initial release
// ============================================================================
package conv1_pkg;

  localparam int PIX_W = 8;                       // bits per channel sample
  localparam int N_CH  = 3;                       // channels per pixel
  localparam int K     = 3;                       // kernel edge length
  localparam int WIN_W = N_CH * K * K * PIX_W;    // 216-bit flattened window

  // One raster pixel: ch0 in [7:0], ch1 in [15:8], ch2 in [23:16]
  typedef logic [N_CH-1:0][PIX_W-1:0] pix_t;

  // Window indexed [ky][kx]; ky=0 oldest row, kx=0 leftmost column
  typedef pix_t [K-1:0][K-1:0] win_t;

  // LSB position of tap k of channel n inside the flattened window
  function automatic int tap_lsb(input int n, input int k);
    return (n * K * K + k) * PIX_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv1_line_buf.sv
`default_nettype none
// ============================================================================
// Module   : conv1_line_buf
// Purpose  : One row of pixel storage; combinational read of the addressed
//            column, write on the clock edge, so a same-cycle read returns
//            the previous contents (read-before-write). Not reset.
// Revision : 1.0 - initial release
// ============================================================================
module conv1_line_buf
  import conv1_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  pix_t              wr_data,
  output pix_t              rd_data
);

  pix_t r_mem [DEPTH];

  assign rd_data = r_mem[addr];

  // Store the new pixel for this column; old contents were already read out
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[addr] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv1_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : conv1_window_gen
// Purpose  : Builds 3x3x3 windows from a raster pixel stream using two line
//            buffers and a shifting window register; emits strided windows.
// Options  : CONV1_WIN_SOF_EN - adds a sof input that forces the accepted
//            pixel to be (0,0) of a new frame.
// Revision : 1.0 - initial release
// ============================================================================
module conv1_window_gen
  import conv1_pkg::*;
#(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int STRIDE = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [23:0]      in_pix,
`ifdef CONV1_WIN_SOF_EN
  input  logic             sof,
`endif
  output logic             out_valid,
  output logic [WIN_W-1:0] out_win,
  output logic             frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] c_col_last = CW'(IMG_W - 1);
  localparam logic [RW-1:0] c_row_last = RW'(IMG_H - 1);
  localparam logic [CW-1:0] c_col_two  = CW'(2);
  localparam logic [RW-1:0] c_row_two  = RW'(2);
  localparam bit            c_stride2  = (STRIDE == 2);

  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic [CW-1:0]    w_col;
  logic [RW-1:0]    w_row;
  win_t             r_win;
  win_t             w_win_next;
  logic [WIN_W-1:0] w_win_flat;
  logic [WIN_W-1:0] r_out_win;
  logic             r_out_valid;
  logic             r_frame_done;
  pix_t             w_in_pix;
  pix_t             w_row1_rd;
  pix_t             w_row2_rd;
  logic             w_col_ok;
  logic             w_row_ok;
  logic             w_qual;
  logic             w_last;

  assign w_in_pix = in_pix;

`ifdef CONV1_WIN_SOF_EN
  assign w_col = sof ? '0 : r_col;
  assign w_row = sof ? '0 : r_row;
`else
  assign w_col = r_col;
  assign w_row = r_row;
`endif

  // Row-1 buffer takes the incoming pixel; row-2 buffer takes what row-1 held
  conv1_line_buf #(.DEPTH(IMG_W), .ADDR_W(CW)) u_row1_buf (
    .clk     (clk),
    .wr_en   (in_valid),
    .addr    (w_col),
    .wr_data (w_in_pix),
    .rd_data (w_row1_rd)
  );

  conv1_line_buf #(.DEPTH(IMG_W), .ADDR_W(CW)) u_row2_buf (
    .clk     (clk),
    .wr_en   (in_valid),
    .addr    (w_col),
    .wr_data (w_row1_rd),
    .rd_data (w_row2_rd)
  );

  // For STRIDE 2, (x-2) is a multiple of 2 exactly when x is even
  assign w_col_ok = (w_col >= c_col_two) && (!c_stride2 || !w_col[0]);
  assign w_row_ok = (w_row >= c_row_two) && (!c_stride2 || !w_row[0]);
  assign w_qual   = in_valid && w_col_ok && w_row_ok;
  assign w_last   = in_valid && (w_col == c_col_last) && (w_row == c_row_last);

  // Shift window one column left and append the new {row-2, row-1, pixel} column
  always_comb begin
    w_win_next = r_win;
    for (int ky = 0; ky < K; ky++) begin
      for (int kx = 0; kx < K - 1; kx++) begin
        w_win_next[ky][kx] = r_win[ky][kx+1];
      end
    end
    w_win_next[0][K-1] = w_row2_rd;
    w_win_next[1][K-1] = w_row1_rd;
    w_win_next[2][K-1] = w_in_pix;
  end

  // Flatten into channel-major, tap-minor output layout
  always_comb begin
    w_win_flat = '0;
    for (int n = 0; n < N_CH; n++) begin
      for (int k = 0; k < K * K; k++) begin
        w_win_flat[tap_lsb(n, k) +: PIX_W] = w_win_next[k / K][k % K][n];
      end
    end
  end

  // Counters, window register and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_col        <= '0;
      r_row        <= '0;
      r_win        <= '0;
      r_out_win    <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_out_valid  <= w_qual;
      r_frame_done <= w_last;
      if (in_valid) begin
        r_win <= w_win_next;
        if (w_col == c_col_last) begin
          r_col <= '0;
          r_row <= (w_row == c_row_last) ? '0 : w_row + 1'b1;
        end else begin
          r_col <= w_col + 1'b1;
          r_row <= w_row;
        end
      end
      if (w_qual) begin
        r_out_win <= w_win_flat;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_win    = r_out_win;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: doc/conv1_window_gen.md
CONV1_WINDOW_GEN -- requirements
Module: conv1_window_gen

Interface
REQ-001 Parameter IMG_W, default 32: input frame width in pixels, minimum 3.
REQ-002 Parameter IMG_H, default 32: input frame height in pixels, minimum 3.
REQ-003 Parameter STRIDE, default 2: window step in both dimensions, 1 or 2.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  in_pix carries one pixel this cycle.
REQ-007 in_pix  input  24  raster-order pixel: ch0 in [7:0], ch1 in [15:8], ch2 in [23:16], signed 8-bit each.
REQ-008 out_valid  output  1  out_win holds a complete 3x3x3 window; connects to conv1 valid.
REQ-009 out_win  output  216  window: channel n in [72n+71:72n]; tap k=ky*3+kx in bits [8k+7:8k] of its channel field; ky=0 is the oldest row, kx=0 the leftmost column.
REQ-010 frame_done  output  1  one-cycle pulse marking end of frame.

Function
REQ-011 The block SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), advanced only on in_valid; col wraps to 0 and increments row; row wraps to 0 after (IMG_H-1, IMG_W-1).
REQ-012 Two line buffers of IMG_W x 24 bits SHALL hold the previous two rows; at each accepted pixel, column col SHALL be read before write (row-1 data moves to the row-2 buffer, in_pix goes to the row-1 buffer).
REQ-013 A 3x3x24-bit window register SHALL shift left by one column on each accepted pixel, loading {row-2, row-1, in_pix} at column col.
REQ-014 A window SHALL be emitted for accepted pixel (row,col) iff row>=2, col>=2, (row-2)%STRIDE==0 and (col-2)%STRIDE==0.
REQ-015 out_valid SHALL assert exactly one cycle after the accepting edge of the qualifying pixel, for one cycle; out_win SHALL be stable while out_valid is high and holds its last value otherwise.
REQ-016 No windows SHALL straddle rows: shift contents from columns of the previous row never reach an emitted window, because col>=2 is required.
REQ-017 Windows per frame SHALL be ((IMG_H-3)/STRIDE+1)*((IMG_W-3)/STRIDE+1), integer division.
REQ-018 in_valid low SHALL freeze counters, line buffers and window; out_valid SHALL be 0 the following cycle.
REQ-019 frame_done SHALL pulse one cycle after acceptance of pixel (IMG_H-1, IMG_W-1), coincident with out_valid when that pixel qualifies.
REQ-020 There is no backpressure; every in_valid pixel SHALL be accepted.

Reset
REQ-021 With rstn low: out_valid=0, out_win=0, frame_done=0, row=0, col=0, window register=0.
REQ-022 Line buffer contents SHALL NOT be reset; their stale data SHALL never be emitted, because rows 0 and 1 are rewritten before the first window.
REQ-023 Reset mid-frame SHALL abandon the frame; the next accepted pixel is (0,0).

Configuration
REQ-024 Macro CONV1_WIN_SOF_EN defined: add input sof (1 bit); sof=1 with in_valid SHALL force that pixel to be (0,0) and update counters from there.
REQ-025 Macro CONV1_WIN_SOF_EN undefined: no sof port; frame alignment SHALL come from counters and reset only.

Structure
REQ-026 Package conv1_pkg SHALL hold PIX_W=8, N_CH=3, K=3, WIN_W=216 and the pixel typedef (N_CH x PIX_W).
REQ-027 Sub-module conv1_line_buf SHALL implement one IMG_W x 24 read-before-write buffer, instantiated twice.

Verification
REQ-028 IMG_W=IMG_H=5, STRIDE=1, every channel = 5*row+col -> first out_valid one cycle after the 13th pixel; each channel taps = 0,1,2,5,6,7,10,11,12; 9 windows total.
REQ-029 Same frame, STRIDE=2 -> exactly 4 windows, at pixels (2,2),(2,4),(4,2),(4,4); last window tap 0 = 12, tap 8 = 24; frame_done coincident with the 4th.
REQ-030 Default 32x32, STRIDE=2, random in_valid gaps (~30% idle) -> 225 windows, bit-exact to the reference model, none emitted during idle cycles.
REQ-031 rstn pulsed after 40 pixels, then a full 5x5 frame -> windows identical to REQ-028, none containing pre-reset data.
REQ-032 CONV1_WIN_SOF_EN defined, sof asserted on the 7th pixel of a 5x5 frame -> that pixel is treated as (0,0) and the REQ-028 sequence follows.
